sd_pattern_gen: RTL

Parametrised srdy/drdy traffic source for block-level benches and built-in self-test. It generates a programmable number of words, with data from one of four modes: increment, decrement, LFSR or constant. A runtime srdy gap pattern shapes the traffic. Start, busy, done and abort controls replace the blocking-task interface. It sits on the producer side of any srdy/drdy block under test.

---
 rtl/sd_patgen_pkg.sv | 20 ++
 rtl/sd_patgen_lfsr.sv | 15 +
 rtl/sd_pattern_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sd_patgen_pkg.sv
// Shared types for the srdy/drdy pattern generator: data modes, FSM states
// and the all-ones "infinite count" marker.
package sd_patgen_pkg;

    typedef enum logic [1:0] {
        MODE_INCR  = 2'd0,
        MODE_DECR  = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_CONST = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Sliced down to cnt_sz by the user; a count of all ones never decrements.
    localparam logic [63:0] CNT_INFINITE = '1;

endpackage

// File: rtl/sd_patgen_lfsr.sv
// Galois LFSR next-state function: shift right, fold taps in when the bit
// shifted out is set.
module sd_patgen_lfsr #(
    parameter int            pw   = 12,
    parameter logic [pw-1:0] taps = '0
) (
    input  logic [pw-1:0] cur,
    output logic [pw-1:0] nxt
);

    always_comb begin
        nxt = (cur >> 1) ^ (cur[0] ? taps : '0);
    end

endmodule

// File: rtl/sd_pattern_gen.sv
// srdy/drdy traffic source: count-limited words in incr/decr/LFSR/const modes,
// shaped by a live srdy gap pattern. SD_PATGEN_SUM_EN adds a running sum output.
module sd_pattern_gen
    import sd_patgen_pkg::*;
#(
    parameter int                    width     = 16,
    parameter int                    tag_sz    = 4,
    parameter logic [tag_sz-1:0]     tag_val   = '0,
    parameter int                    pat_dep   = 8,
    parameter int                    cnt_sz    = 16,
    parameter logic [width-1:0]      lfsr_taps = 16'hB400
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [cnt_sz-1:0]        count,
    input  logic [1:0]               mode,
    input  logic [width-tag_sz-1:0]  seed,
    input  logic [pat_dep-1:0]       srdy_pat,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     p_srdy,
    input  logic                     p_drdy,
    output logic [width-1:0]         p_data
`ifdef SD_PATGEN_SUM_EN
    ,
    output logic [width-1:0]         sum
`endif
);

    localparam int pw    = width - tag_sz;
    localparam int spp_w = (pat_dep > 1) ? $clog2(pat_dep) : 1;

    localparam logic [cnt_sz-1:0] inf_cnt   = CNT_INFINITE[cnt_sz-1:0];
    localparam logic [spp_w-1:0]  spp_last  = spp_w'(pat_dep - 1);
    localparam logic [spp_w-1:0]  spp_first = (pat_dep > 1) ? spp_w'(1) : '0;

    state_e             state;
    mode_e              mode_q;
    logic [pw-1:0]      payload;
    logic [cnt_sz-1:0]  rem;
    logic [spp_w-1:0]   spp;

    logic               xfer;
    logic               slot;
    logic               finish;
    logic [cnt_sz-1:0]  rem_after;
    logic [spp_w-1:0]   spp_nxt;
    logic [pw-1:0]      lfsr_nxt;
    logic [pw-1:0]      pay_nxt;
    logic [pw-1:0]      seed_eff;

    assign p_data = {tag_val, payload};

    assign xfer      = p_srdy & p_drdy;
    assign slot      = !p_srdy | xfer;
    assign rem_after = (xfer && rem != inf_cnt) ? rem - cnt_sz'(1) : rem;
    assign finish    = slot & ((rem_after == '0) | abort);
    assign spp_nxt   = (spp == spp_last) ? '0 : spp + spp_w'(1);

    // An all-zero LFSR would lock up, so a zero seed starts from 1.
    assign seed_eff  = (mode_e'(mode) == MODE_LFSR && seed == '0) ? pw'(1) : seed;

    sd_patgen_lfsr #(
        .pw   (pw),
        .taps (lfsr_taps[pw-1:0])
    ) u_lfsr (
        .cur  (payload),
        .nxt  (lfsr_nxt)
    );

    always_comb begin
        pay_nxt = payload;
        case (mode_q)
            MODE_INCR: pay_nxt = payload + pw'(1);
            MODE_DECR: pay_nxt = payload - pw'(1);
            MODE_LFSR: pay_nxt = lfsr_nxt;
            default:   pay_nxt = payload;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            mode_q  <= MODE_INCR;
            payload <= '0;
            rem     <= '0;
            spp     <= '0;
            p_srdy  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            state   <= ST_RUN;
                            busy    <= 1'b1;
                            rem     <= count;
                            mode_q  <= mode_e'(mode);
                            payload <= seed_eff;
                            // The start edge is the first slot, so a word can be
                            // offered in the very next cycle.
                            p_srdy  <= srdy_pat[0] & !abort;
                            spp     <= spp_first;
                        end else begin
                            done    <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (slot) begin
                        rem <= rem_after;
                        if (xfer)
                            payload <= pay_nxt;
                        if (finish) begin
                            state  <= ST_IDLE;
                            busy   <= 1'b0;
                            p_srdy <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            p_srdy <= srdy_pat[spp];
                            spp    <= spp_nxt;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SD_PATGEN_SUM_EN
    always_ff @(posedge clk) begin
        if (reset)
            sum <= '0;
        else if (state == ST_IDLE && start)
            sum <= '0;
        else if (xfer)
            sum <= sum + p_data;
    end
`endif

endmodule
